// File: rtl/incline_integrator.sv
// incline_integrator: calibrates the pitch-rate zero offset, integrates the
// offset-corrected rate into a saturating 27-bit accumulator, and nudges the
// accumulator toward an accelerometer angle so it cannot drift.
`timescale 1ns/1ps
module incline_integrator #(
  parameter int CAL_SHIFT   = 4,
  parameter int FUSION_STEP = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic signed [15:0] pitch_rt,
  input  logic signed [15:0] AZ,
  input  logic               cal,
  output logic signed [12:0] incline,
  output logic               incline_vld,
  output logic               cal_done
);

  localparam int DATA_W = 16;
  localparam int ACC_W  = DATA_W + CAL_SHIFT;
  localparam int INT_W  = 27;
  localparam int SUM_W  = INT_W + 1;
  localparam logic signed [SUM_W-1:0] FSTEP = SUM_W'(FUSION_STEP);

  typedef enum logic {S_CAL, S_RUN} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CAL_SHIFT-1:0]       r_cal_cnt;
  logic signed [ACC_W-1:0]    r_cal_acc;
  logic signed [DATA_W-1:0]   r_offset;
  logic signed [INT_W-1:0]    r_integ;
  logic                       r_vld_p1;

  logic                       w_cal_last;
  logic signed [ACC_W-1:0]    w_cal_sum;
  logic signed [DATA_W-1:0]   w_offset_new;
  logic signed [DATA_W:0]     w_rate_comp;
  logic signed [12:0]         w_accel_incl;
  logic signed [12:0]         w_incline;
  logic signed [SUM_W-1:0]    w_fusion;
  logic signed [SUM_W-1:0]    w_sum_p0;

  // Clamp a 28-bit sum into the 27-bit integrator range instead of wrapping.
  function automatic logic signed [INT_W-1:0] sat_integ(input logic signed [SUM_W-1:0] x);
    if (x[SUM_W-1] != x[SUM_W-2])
      sat_integ = x[SUM_W-1] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    else
      sat_integ = x[INT_W-1:0];
  endfunction

  assign w_cal_last   = &r_cal_cnt;
  assign w_cal_sum    = r_cal_acc + {{CAL_SHIFT{pitch_rt[DATA_W-1]}}, pitch_rt};
  assign w_offset_new = DATA_W'(w_cal_sum >>> CAL_SHIFT);
  assign w_rate_comp  = {pitch_rt[DATA_W-1], pitch_rt} - {r_offset[DATA_W-1], r_offset};
  assign w_accel_incl = 13'(AZ >>> 3);
  assign w_incline    = r_integ[26:14];

  // Fusion direction: pull the current estimate toward the accel angle.
  always_comb begin
    w_fusion = '0;
    if (w_incline > w_accel_incl)
      w_fusion = -FSTEP;
    else if (w_incline < w_accel_incl)
      w_fusion = FSTEP;
  end

  assign w_sum_p0 = {r_integ[INT_W-1], r_integ}
                  + {{(SUM_W-DATA_W-1){w_rate_comp[DATA_W]}}, w_rate_comp}
                  + w_fusion;

  // Next-state logic: cal restarts calibration; the last calibration sample enters RUN.
  always_comb begin
    w_state_nxt = r_state;
    if (cal)
      w_state_nxt = S_CAL;
    else if (vld && (r_state == S_CAL) && w_cal_last)
      w_state_nxt = S_RUN;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_CAL;
    else
      r_state <= w_state_nxt;
  end

  // Calibration accumulator, offset and integrator updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cal_cnt <= '0;
      r_cal_acc <= '0;
      r_offset  <= '0;
      r_integ   <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (cal) begin
        r_cal_cnt <= '0;
        r_cal_acc <= '0;
        r_integ   <= '0;
      end else if (vld) begin
        if (r_state == S_CAL) begin
          r_cal_acc <= w_cal_sum;
          r_cal_cnt <= r_cal_cnt + 1'b1;
          if (w_cal_last)
            r_offset <= w_offset_new;
        end else begin
          // stage p0 -> p1: saturated integrator and its valid strobe
          r_integ  <= sat_integ(w_sum_p0);
          r_vld_p1 <= 1'b1;
        end
      end
    end
  end

  assign incline     = w_incline;
  assign incline_vld = r_vld_p1;
  assign cal_done    = (r_state == S_RUN);

endmodule

// File: tb/tb_incline_integrator.sv
// Bench for incline_integrator: a transaction-level model updated per clock,
// a per-cycle compare process, and literal checkpoints that pin the model.
`timescale 1ns/1ps
module tb_incline_integrator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               vld = 1'b0;
  logic signed [15:0] pitch_rt = '0;
  logic signed [15:0] AZ = '0;
  logic               cal = 1'b0;
  logic signed [12:0] incline;
  logic               incline_vld;
  logic               cal_done;

  incline_integrator #(.CAL_SHIFT(4), .FUSION_STEP(1024)) dut (
    .clk(clk), .rst(rst), .vld(vld), .pitch_rt(pitch_rt), .AZ(AZ),
    .cal(cal), .incline(incline), .incline_vld(incline_vld), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model state
  bit     m_run;
  int     m_cnt;
  longint m_acc;
  longint m_offset;
  longint m_integ;
  bit     m_vld;

  localparam longint IMAX = 67108863;
  localparam longint IMIN = -67108864;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint m_incline();
    return m_integ >>> 14;
  endfunction

  // Apply one cycle of inputs and advance the model by the same clock.
  task automatic step(input bit r, input bit c, input bit v, input int pr, input int az);
    longint rate, accel, fus, s, inc;
    rst = r; cal = c; vld = v; pitch_rt = 16'(pr); AZ = 16'(az);
    @(posedge clk);
    m_vld = 1'b0;
    if (r) begin
      m_run = 0; m_cnt = 0; m_acc = 0; m_offset = 0; m_integ = 0;
    end else if (c) begin
      m_run = 0; m_cnt = 0; m_acc = 0; m_integ = 0;
    end else if (v) begin
      if (!m_run) begin
        m_acc += pr;
        m_cnt++;
        if (m_cnt == 16) begin
          m_offset = m_acc >>> 4;
          m_run = 1;
          m_cnt = 0;
        end
      end else begin
        rate  = longint'(pr) - m_offset;
        accel = longint'(az) >>> 3;
        inc   = m_incline();
        fus   = (inc > accel) ? -1024 : ((inc < accel) ? 1024 : 0);
        s     = m_integ + rate + fus;
        if (s > IMAX) s = IMAX;
        if (s < IMIN) s = IMIN;
        m_integ = s;
        m_vld = 1'b1;
      end
    end
    #1;
  endtask

  task automatic sample(input int pr, input int az);
    step(1'b0, 1'b0, 1'b1, pr, az);
  endtask

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("incline", longint'(incline), m_incline());
      chk("incline_vld", longint'(incline_vld), longint'(m_vld));
      chk("cal_done", longint'(cal_done), longint'(m_run));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 123, 456);
    chk_en = 1'b1;
    chk("reset_incline", longint'(incline), 0);
    chk("reset_vld", longint'(incline_vld), 0);
    chk("reset_cal_done", longint'(cal_done), 0);

    // calibrate with 100
    for (int i = 1; i <= 16; i++) begin
      sample(100, 0);
      if (i == 15) chk("cal_done_before_16", longint'(cal_done), 0);
    end
    chk("cal_done_after_16", longint'(cal_done), 1);
    chk("model_offset_100", m_offset, 100);
    step(0, 0, 0, 0, 0);

    // two run samples
    sample(16484, 0);
    chk("run1_incline", longint'(incline), 1);
    chk("run1_vld", longint'(incline_vld), 1);
    chk("run1_model_integ", m_integ, 16384);
    sample(16484, 0);
    chk("run2_incline", longint'(incline), 1);
    chk("run2_model_integ", m_integ, 31744);
    step(0, 0, 0, 0, 0);
    chk("idle_vld", longint'(incline_vld), 0);

    // fusion climb toward accel angle 1000
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) sample(0, 0);
    for (int k = 1; k <= 16100; k++) begin
      sample(0, 8000);
      if (k == 15999) chk("fusion_k15999", longint'(incline), 999);
      if (k == 16000) chk("fusion_k16000", longint'(incline), 1000);
    end
    chk("fusion_final", longint'(incline), 1000);

    // cal together with vld in RUN
    step(0, 1, 1, 5000, 0);
    chk("calvld_incline", longint'(incline), 0);
    chk("calvld_done", longint'(cal_done), 0);
    chk("calvld_vld", longint'(incline_vld), 0);
    for (int i = 1; i <= 16; i++) begin
      sample((i == 16) ? -6 : -5, 0);
      if (i == 15) chk("recal_done_15", longint'(cal_done), 0);
    end
    chk("recal_done_16", longint'(cal_done), 1);
    sample(16378, 0);
    chk("neg_offset_incline", longint'(incline), 1);

    // rst with vld mid-calibration (cal_cnt = 7)
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) sample(0, 0);
    step(1, 0, 1, 0, 0);
    chk("rstcal_done", longint'(cal_done), 0);
    for (int i = 1; i <= 16; i++) begin
      sample(0, 0);
      if (i == 15) chk("rstcal_done_15", longint'(cal_done), 0);
    end
    chk("rstcal_done_16", longint'(cal_done), 1);

    // positive saturation
    for (int k = 1; k <= 2500; k++) begin
      sample(32767, 32767);
      if (k == 1985) chk("sat_pos_k1985", longint'(incline), 4093);
      if (k == 1986) chk("sat_pos_k1986", longint'(incline), 4095);
    end
    chk("sat_pos_final", longint'(incline), 4095);
    chk("sat_pos_model", m_integ, IMAX);

    // rst with vld in RUN
    step(1, 0, 1, 32767, 0);
    chk("rstrun_incline", longint'(incline), 0);
    chk("rstrun_done", longint'(cal_done), 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) sample(0, 0);

    // negative saturation
    for (int k = 1; k <= 2500; k++) sample(-32768, -32768);
    chk("sat_neg_final", longint'(incline), -4096);
    chk("sat_neg_model", m_integ, IMIN);

    // idle hold
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1000, 1000);
    chk("hold_incline", longint'(incline), -4096);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
